// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. It merges the
//               stage stall requests, runs the divider occupancy counter and
//               turns exception/ERET requests into a timed flush + redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int DIV_CYCLES   = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_stall_req,
    input  logic              ex_stall_req,
    input  logic              mem_stall_req,
    input  logic              div_start,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_target,
    output logic [3:0]        stall,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              memwb_bubble,
    output logic              flush,
    output logic              flush_pc_valid,
    output logic [ADDR_W-1:0] flush_pc,
    output logic              div_busy,
    output logic              div_done
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_DIV_RUN    = 2'd1;
    localparam logic [1:0] c_FLUSH      = 2'd2;
    localparam logic [5:0] c_DIV_LOAD   = 6'(DIV_CYCLES - 1);
    localparam logic [1:0] c_FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]        r_state;
    logic [5:0]        r_cnt;
    logic [1:0]        r_fcnt;
    logic              r_flush_pc_valid;
    logic [ADDR_W-1:0] r_flush_pc;

    logic w_in_idle;
    logic w_in_div;
    logic w_in_flush;
    logic w_take_exc;
    logic w_div_hold;

    assign w_in_idle  = (r_state == c_IDLE);
    assign w_in_div   = (r_state == c_DIV_RUN);
    assign w_in_flush = (r_state == c_FLUSH);
    // A flush in progress masks any further exception request.
    assign w_take_exc = exc_req & ~w_in_flush;
    assign w_div_hold = (w_in_idle & div_start & ~exc_req) | (w_in_div & (r_cnt != 6'd0));

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state          <= c_IDLE;
            r_cnt            <= 6'd0;
            r_fcnt           <= 2'd0;
            r_flush_pc_valid <= 1'b0;
            r_flush_pc       <= '0;
        end else begin
            r_flush_pc_valid <= w_take_exc;
            if (w_take_exc) begin
                r_state    <= c_FLUSH;
                r_fcnt     <= c_FLUSH_LOAD;
                r_flush_pc <= exc_target;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (div_start) begin
                            r_state <= c_DIV_RUN;
                            r_cnt   <= c_DIV_LOAD;
                        end
                    end
                    c_DIV_RUN: begin
                        if (r_cnt == 6'd0) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                    c_FLUSH: begin
                        if (r_fcnt == 2'd0) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_fcnt <= r_fcnt - 2'd1;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign flush          = w_in_flush;
    assign flush_pc_valid = r_flush_pc_valid;
    assign flush_pc       = r_flush_pc;
    assign div_busy       = w_in_div;
    assign div_done       = w_in_div & (r_cnt == 6'd0) & ~exc_req;

    // Outputs are forced quiet while reset is held, even with requests active.
    always_comb begin
        stall        = 4'b0000;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        if (!resetn && !w_in_flush) begin
            if (mem_stall_req) begin
                stall        = 4'b1111;
                memwb_bubble = 1'b1;
            end else if (ex_stall_req || w_div_hold) begin
                stall        = 4'b0111;
                exmem_bubble = 1'b1;
            end else if (id_stall_req) begin
                stall        = 4'b0011;
                idex_bubble  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (DIV_CYCLES=32, FLUSH_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    typedef struct packed {
        logic [3:0] stall;
        logic       idb;
        logic       exb;
        logic       mwb;
        logic       fl;
        logic       fpv;
        logic       busy;
        logic       done;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        mem_stall_req;
    logic        div_start;
    logic        exc_req;
    logic [31:0] exc_target;
    logic [3:0]  stall;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic        memwb_bubble;
    logic        flush;
    logic        flush_pc_valid;
    logic [31:0] flush_pc;
    logic        div_busy;
    logic        div_done;
    logic [10:0] obs;

    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    pipe_ctrl #(
        .DIV_CYCLES  (32),
        .FLUSH_CYCLES(3),
        .ADDR_W      (32)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .id_stall_req  (id_stall_req),
        .ex_stall_req  (ex_stall_req),
        .mem_stall_req (mem_stall_req),
        .div_start     (div_start),
        .exc_req       (exc_req),
        .exc_target    (exc_target),
        .stall         (stall),
        .idex_bubble   (idex_bubble),
        .exmem_bubble  (exmem_bubble),
        .memwb_bubble  (memwb_bubble),
        .flush         (flush),
        .flush_pc_valid(flush_pc_valid),
        .flush_pc      (flush_pc),
        .div_busy      (div_busy),
        .div_done      (div_done)
    );

    assign obs = {stall, idex_bubble, exmem_bubble, memwb_bubble, flush, flush_pc_valid, div_busy, div_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic id, input logic ex, input logic mem, input logic ds,
                         input logic exc, input logic [31:0] tgt);
        id_stall_req  = id;
        ex_stall_req  = ex;
        mem_stall_req = mem;
        div_start     = ds;
        exc_req       = exc;
        exc_target    = tgt;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (obs !== 11'd0 || flush_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hold obs=%b flush_pc=%h required all zero", obs, flush_pc);
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        for (int c = 0; c < 8; c++) begin
            e = '0;
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL reset_idle c=%0d obs=%b required=%b", c, obs, got);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_prio();
        exp_t e;
        exp_t got;
        for (int c = 0; c < 8; c++) begin
            drive(c[0], c[1], c[2], 0, 0, 32'h0);
            e = '0;
            if (c[2]) begin
                e.stall = 4'b1111; e.mwb = 1'b1;
            end else if (c[1]) begin
                e.stall = 4'b0111; e.exb = 1'b1;
            end else if (c[0]) begin
                e.stall = 4'b0011; e.idb = 1'b1;
            end
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL stall_prio id/ex/mem=%b obs=%b required=%b", c[2:0], obs, got);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic test_div();
        exp_t e;
        exp_t got;
        for (int c = 0; c < 46; c++) begin
            drive(0, 0, 0, (c >= 10 && c <= 42), 0, 32'h0);
            e       = '0;
            e.stall = (c >= 10 && c <= 41) ? 4'b0111 : 4'b0000;
            e.exb   = (c >= 10 && c <= 41);
            e.busy  = (c >= 11 && c <= 42);
            e.done  = (c == 42);
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL div_latency c=%0d obs=%b required=%b", c, obs, got);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exc_div();
        exp_t e;
        exp_t got;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, (c == 0), (c == 20), (c == 20) ? 32'hBFC00380 : 32'h0);
            e       = '0;
            e.stall = (c <= 20) ? 4'b0111 : 4'b0000;
            e.exb   = (c <= 20);
            e.busy  = (c >= 1 && c <= 20);
            e.fl    = (c >= 21 && c <= 23);
            e.fpv   = (c == 21);
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL exc_during_div c=%0d obs=%b required=%b", c, obs, got);
            end
            if (c >= 21) begin
                n_cmp++;
                if (flush_pc !== 32'hBFC00380) begin
                    n_bad++;
                    $display("FAIL exc_div_pc c=%0d flush_pc=%h required=bfc00380", c, flush_pc);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_ignore();
        exp_t        e;
        exp_t        got;
        logic [31:0] tgt;
        logic [31:0] want_pc;
        for (int c = 0; c < 18; c++) begin
            tgt = (c == 5) ? 32'h80000180 : (c == 6) ? 32'h12345678 :
                  (c == 12) ? 32'hA5A50000 : 32'h0;
            drive((c == 10), 0, (c == 7), (c == 6 || c == 12),
                  (c == 5 || c == 6 || c == 12), tgt);
            e       = '0;
            e.fl    = (c >= 6 && c <= 8) || (c >= 13 && c <= 15);
            e.fpv   = (c == 6 || c == 13);
            e.stall = (c == 10) ? 4'b0011 : 4'b0000;
            e.idb   = (c == 10);
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL flush_ignore c=%0d obs=%b required=%b", c, obs, got);
            end
            if (c >= 6) begin
                want_pc = (c >= 13) ? 32'hA5A50000 : 32'h80000180;
                n_cmp++;
                if (flush_pc !== want_pc) begin
                    n_bad++;
                    $display("FAIL flush_pc_hold c=%0d flush_pc=%h required=%h", c, flush_pc, want_pc);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        exp_t got;
        for (int c = 0; c < 22; c++) begin
            drive(0, 0, 0, (c == 0), 0, 32'h0);
            e       = '0;
            e.stall = 4'b0111;
            e.exb   = 1'b1;
            e.busy  = (c >= 1);
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL pre_reset_div c=%0d obs=%b required=%b", c, obs, got);
            end
            @(posedge clk); #1;
        end
        // Counter now sits at 10; pulse reset between edges.
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 11'd0 || flush_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset obs=%b flush_pc=%h required all zero", obs, flush_pc);
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        for (int c = 0; c < 36; c++) begin
            drive(0, 0, ((c >= 5 && c <= 7) || c == 32), (c == 0), 0, 32'h0);
            e = '0;
            if ((c >= 5 && c <= 7) || c == 32) begin
                e.stall = 4'b1111; e.mwb = 1'b1;
            end else if (c <= 31) begin
                e.stall = 4'b0111; e.exb = 1'b1;
            end
            e.busy = (c >= 1 && c <= 32);
            e.done = (c == 32);
            sb.push_back(e);
            @(negedge clk);
            got = sb.pop_front();
            n_cmp++;
            if (obs !== got) begin
                n_bad++;
                $display("FAIL post_reset_div c=%0d obs=%b required=%b", c, obs, got);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stall_prio();
        test_div();
        test_exc_div();
        test_flush_ignore();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
